// File: rtl/lattic_pkg.sv
// Shared types, frame constants and glyph helpers for the lattic_pattern frame source.
package lattic_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAlarm = 2'd1,
        StTaken = 2'd2
    } state_e;

    localparam logic [63:0] PILL    = 64'h003c3c3c24183C00;
    localparam logic [63:0] GLYPH_A = 64'h0042427e42241800;
    localparam logic [63:0] GLYPH_B = 64'h1C24241C24241C00;
    localparam logic [63:0] GLYPH_C = 64'h001C220202221C00;

    // sel 3 is never latched; it maps to a blank frame for completeness.
    function automatic logic [63:0] glyph_lookup(input logic [1:0] sel);
        logic [63:0] g;
        case (sel)
            2'd0:    g = GLYPH_A;
            2'd1:    g = GLYPH_B;
            2'd2:    g = GLYPH_C;
            default: g = 64'h0;
        endcase
        return g;
    endfunction

    function automatic logic [63:0] rotate_rows(input logic [63:0] g, input logic [2:0] n);
        logic [63:0] res;
        logic [15:0] dbl;
        res = 64'h0;
        for (int k = 0; k < 8; k++) begin
            dbl = {g[8*k +: 8], g[8*k +: 8]} << n;
            res[8*k +: 8] = dbl[15:8];
        end
        return res;
    endfunction

endpackage

// File: rtl/lattic_ms_tick.sv
// Free-running 1 ms tick generator: one-cycle pulse at the terminal count.
module lattic_ms_tick #(
    parameter int unsigned CLK_PER_MS = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int unsigned CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_MS - 1);

    logic [CW-1:0] r_cnt;
    logic          w_tick;

    assign w_tick = (r_cnt == CNT_LAST);
    assign o_tick = w_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lattic_pattern.sv
// Pill-box frame source: idle icon, blinking alarm glyph, timed green confirmation glyph.
// Optional LATTIC_SCROLL_EN rotates each green row while the confirmation glyph is shown.
module lattic_pattern
    import lattic_pkg::*;
#(
    parameter int unsigned CLK_PER_MS = 50000,
    parameter int unsigned BLINK_MS   = 250,
    parameter int unsigned TAKEN_MS   = 3000,
    parameter int unsigned SCROLL_MS  = 125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alarm_req,
    input  logic [1:0]  med_sel,
    input  logic        ack,
    output logic [63:0] r_dis,
    output logic [63:0] g_dis,
    output logic        alarm_o,
    output logic [1:0]  state_o
);

    localparam int unsigned BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
    localparam int unsigned HW = (TAKEN_MS > 1) ? $clog2(TAKEN_MS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(TAKEN_MS - 1);

    state_e        r_state, w_state_d;
    logic [1:0]    r_sel, w_sel_d;
    logic [BW-1:0] r_blink, w_blink_d;
    logic          r_phase, w_phase_d;
    logic [HW-1:0] r_hold, w_hold_d;
    logic [63:0]   r_red, r_green, w_red_d, w_green_d;
    logic          r_alarm, w_alarm_d;
    logic [63:0]   w_taken_glyph;
    logic          w_tick;
    logic          w_req_valid;

    lattic_ms_tick #(
        .CLK_PER_MS (CLK_PER_MS)
    ) u_ms_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    assign w_req_valid = alarm_req && (med_sel != 2'd3);

    always_comb begin
        w_state_d = r_state;
        w_sel_d   = r_sel;
        w_blink_d = r_blink;
        w_phase_d = r_phase;
        w_hold_d  = r_hold;
        case (r_state)
            StIdle: begin
                if (w_req_valid) begin
                    w_state_d = StAlarm;
                    w_sel_d   = med_sel;
                    w_blink_d = '0;
                    w_phase_d = 1'b1;
                end
            end
            StAlarm: begin
                if (ack) begin
                    w_state_d = StTaken;
                    w_hold_d  = '0;
                end else if (w_tick) begin
                    if (r_blink == BLINK_LAST) begin
                        w_blink_d = '0;
                        w_phase_d = ~r_phase;
                    end else begin
                        w_blink_d = r_blink + 1'b1;
                    end
                end
            end
            StTaken: begin
                // A fresh alarm pre-empts the confirmation hold.
                if (w_req_valid) begin
                    w_state_d = StAlarm;
                    w_sel_d   = med_sel;
                    w_blink_d = '0;
                    w_phase_d = 1'b1;
                end else if (w_tick) begin
                    if (r_hold == HOLD_LAST) begin
                        w_state_d = StIdle;
                    end else begin
                        w_hold_d = r_hold + 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

`ifdef LATTIC_SCROLL_EN
    localparam int unsigned SW = (SCROLL_MS > 1) ? $clog2(SCROLL_MS) : 1;
    localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_MS - 1);

    logic [SW-1:0] r_scroll_cnt, w_scroll_cnt_d;
    logic [2:0]    r_offset, w_offset_d;

    always_comb begin
        w_scroll_cnt_d = r_scroll_cnt;
        w_offset_d     = r_offset;
        if ((r_state == StTaken) && (w_state_d == StTaken)) begin
            if (w_tick) begin
                if (r_scroll_cnt == SCROLL_LAST) begin
                    w_scroll_cnt_d = '0;
                    w_offset_d     = r_offset + 3'd1;
                end else begin
                    w_scroll_cnt_d = r_scroll_cnt + 1'b1;
                end
            end
        end else begin
            w_scroll_cnt_d = '0;
            w_offset_d     = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scroll_cnt <= '0;
            r_offset     <= 3'd0;
        end else begin
            r_scroll_cnt <= w_scroll_cnt_d;
            r_offset     <= w_offset_d;
        end
    end

    assign w_taken_glyph = rotate_rows(glyph_lookup(w_sel_d), w_offset_d);
`else
    logic w_unused_scroll;
    assign w_unused_scroll = (SCROLL_MS == 0);
    assign w_taken_glyph   = glyph_lookup(w_sel_d);
`endif

    // Outputs are decoded from next-state so they land on the same edge as the transition.
    always_comb begin
        w_red_d   = 64'h0;
        w_green_d = PILL;
        w_alarm_d = 1'b0;
        case (w_state_d)
            StAlarm: begin
                w_red_d   = w_phase_d ? glyph_lookup(w_sel_d) : 64'h0;
                w_green_d = 64'h0;
                w_alarm_d = 1'b1;
            end
            StTaken: begin
                w_green_d = w_taken_glyph;
            end
            default: begin
                w_red_d   = 64'h0;
                w_green_d = PILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_sel   <= 2'd0;
            r_blink <= '0;
            r_phase <= 1'b0;
            r_hold  <= '0;
            r_red   <= 64'h0;
            r_green <= PILL;
            r_alarm <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_sel   <= w_sel_d;
            r_blink <= w_blink_d;
            r_phase <= w_phase_d;
            r_hold  <= w_hold_d;
            r_red   <= w_red_d;
            r_green <= w_green_d;
            r_alarm <= w_alarm_d;
        end
    end

    assign r_dis   = r_red;
    assign g_dis   = r_green;
    assign alarm_o = r_alarm;
    assign state_o = r_state;

endmodule

// File: tb/tb_lattic_pattern.sv
// Scoreboard bench for lattic_pattern: expectations are queued per cycle and checked by a monitor.
module tb_lattic_pattern;

    localparam logic [63:0] PILL_C = 64'h003c3c3c24183C00;
    localparam logic [63:0] GA     = 64'h0042427e42241800;
    localparam logic [63:0] GB     = 64'h1C24241C24241C00;
    localparam logic [63:0] GC     = 64'h001C220202221C00;

    logic        clk;
    logic        rst_n;
    logic        alarm_req;
    logic [1:0]  med_sel;
    logic        ack;
    logic [63:0] r_dis;
    logic [63:0] g_dis;
    logic        alarm_o;
    logic [1:0]  state_o;

    typedef struct {
        int          cyc;
        string       name;
        logic [1:0]  st;
        logic        al;
        logic [63:0] r;
        logic [63:0] g;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   base;
    int   n_total;
    int   n_pass;

    lattic_pattern #(
        .CLK_PER_MS (4),
        .BLINK_MS   (2),
        .TAKEN_MS   (5),
        .SCROLL_MS  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alarm_req (alarm_req),
        .med_sel   (med_sel),
        .ack       (ack),
        .r_dis     (r_dis),
        .g_dis     (g_dis),
        .alarm_o   (alarm_o),
        .state_o   (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected green frame in TAKEN after n scroll steps.
    function automatic logic [63:0] tg(input logic [63:0] glyph, input int n);
        logic [63:0] res;
        res = glyph;
`ifdef LATTIC_SCROLL_EN
        res = 64'h0;
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < 8; i++)
                res[k*8 + ((i + n) % 8)] = glyph[k*8 + i];
`endif
        return res;
    endfunction

    task automatic push(input int c, input string nm, input logic [1:0] st, input logic al,
                        input logic [63:0] r, input logic [63:0] g);
        exp_t e;
        e.cyc = c; e.name = nm; e.st = st; e.al = al; e.r = r; e.g = g;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic align();
        while (((cyc - base) % 4) != 0) step(1);
    endtask

    task automatic cmp(input string nm, input string fld, input logic [63:0] act,
                       input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s.%s @cyc %0d: got %h expected %h", nm, fld, cyc, act, req);
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                n_total++;
                $display("FAIL %s.missed: sampled at %0d expected at %0d", e.name, cyc, e.cyc);
            end else begin
                cmp(e.name, "state_o", 64'(state_o), 64'(e.st));
                cmp(e.name, "alarm_o", 64'(alarm_o), 64'(e.al));
                cmp(e.name, "r_dis", r_dis, e.r);
                cmp(e.name, "g_dis", g_dis, e.g);
            end
        end
    end

    initial begin
        int e0;
        n_total = 0;
        n_pass  = 0;
        base    = 0;
        rst_n = 1'b0; alarm_req = 1'b0; med_sel = 2'd0; ack = 1'b0;
        step(3);
        push(cyc, "reset", 2'd0, 1'b0, 64'h0, PILL_C);
        step(1);
        rst_n = 1'b1;
        base  = cyc;

        // Alarm for medicine B and its blink cadence.
        align();
        e0 = cyc;
        alarm_req = 1'b1; med_sel = 2'd1;
        push(e0 + 1,  "alarmB_entry", 2'd1, 1'b1, GB, 64'h0);
        push(e0 + 7,  "alarmB_on1",   2'd1, 1'b1, GB, 64'h0);
        push(e0 + 8,  "alarmB_off",   2'd1, 1'b1, 64'h0, 64'h0);
        push(e0 + 15, "alarmB_off2",  2'd1, 1'b1, 64'h0, 64'h0);
        push(e0 + 16, "alarmB_on2",   2'd1, 1'b1, GB, 64'h0);
        step(1);
        alarm_req = 1'b0;
        step(16);

        // Asynchronous reset during the blink.
        rst_n = 1'b0;
        push(cyc, "reset_mid_alarm", 2'd0, 1'b0, 64'h0, PILL_C);
        step(2);
        rst_n = 1'b1;
        base  = cyc;

        // Invalid select and stray ack in IDLE.
        step(2);
        alarm_req = 1'b1; med_sel = 2'd3;
        push(cyc + 1, "idle_sel3", 2'd0, 1'b0, 64'h0, PILL_C);
        push(cyc + 2, "idle_ack",  2'd0, 1'b0, 64'h0, PILL_C);
        step(1);
        alarm_req = 1'b0; ack = 1'b1;
        step(1);
        ack = 1'b0;

        // Alarm A, then ack racing a new request, then hold expiry.
        align();
        e0 = cyc;
        alarm_req = 1'b1; med_sel = 2'd0;
        push(e0 + 1, "alarmA_entry", 2'd1, 1'b1, GA, 64'h0);
        step(1);
        ack = 1'b1; alarm_req = 1'b1; med_sel = 2'd2;
        push(e0 + 2,  "ack_wins",    2'd2, 1'b0, 64'h0, tg(GA, 0));
        push(e0 + 3,  "taken_hold0", 2'd2, 1'b0, 64'h0, tg(GA, 0));
        push(e0 + 4,  "taken_tick1", 2'd2, 1'b0, 64'h0, tg(GA, 1));
        push(e0 + 19, "taken_last",  2'd2, 1'b0, 64'h0, tg(GA, 4));
        push(e0 + 20, "taken_exit",  2'd0, 1'b0, 64'h0, PILL_C);
        step(1);
        ack = 1'b0; alarm_req = 1'b0; med_sel = 2'd0;
        step(19);

        // Alarm C, ack, then alarm A pre-empting the hold.
        align();
        e0 = cyc;
        alarm_req = 1'b1; med_sel = 2'd2;
        push(e0 + 1, "alarmC_entry", 2'd1, 1'b1, GC, 64'h0);
        step(1);
        alarm_req = 1'b0; ack = 1'b1;
        push(e0 + 2, "takenC", 2'd2, 1'b0, 64'h0, tg(GC, 0));
        step(1);
        ack = 1'b0; alarm_req = 1'b1; med_sel = 2'd0;
        push(e0 + 3, "taken_realarm", 2'd1, 1'b1, GA, 64'h0);
        push(e0 + 4, "alarm_req_ign", 2'd1, 1'b1, GA, 64'h0);
        push(e0 + 7, "realarm_on",    2'd1, 1'b1, GA, 64'h0);
        push(e0 + 8, "realarm_off",   2'd1, 1'b1, 64'h0, 64'h0);
        step(1);
        med_sel = 2'd1;
        step(1);
        alarm_req = 1'b0; med_sel = 2'd0;
        step(6);

        for (int i = 0; i < 50 && q.size() > 0; i++) step(1);
        if (q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
